byte_packer: RTL and testbench
==============================

BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 Parameter MSB_FIRST, default 1, selects byte order: 1 = first accepted byte lands in out_word[31:24]; 0 = first byte lands in out_word[7:0].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clr  input  1  synchronous flush; discards any partial or held word.
REQ-005 in_valid  input  1  in_byte is valid this cycle.
REQ-006 in_byte  input  8  byte to pack.
REQ-007 in_ready  output  1  packer can accept in_byte this cycle.
REQ-008 out_valid  output  1  out_word holds a complete 32-bit word.
REQ-009 out_word  output  32  assembled word; inverse of a 4-way byte split.
REQ-010 out_ready  input  1  consumer takes out_word this cycle.
REQ-011 byte_cnt  output  2  bytes held in the partial word (0-3).

Function
REQ-012 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer on a cycle with out_valid && out_ready.
REQ-013 Two states SHALL exist: FILL (collecting bytes) and HOLD (full word presented).
REQ-014 In FILL, in_ready SHALL be 1 and out_valid 0.
REQ-015 In FILL, byte k (k = byte_cnt) SHALL be written to lane 3-k when MSB_FIRST=1, or lane k when MSB_FIRST=0; other lanes hold.
REQ-016 Accepting the 4th byte SHALL move the state to HOLD, wrap byte_cnt to 0 and raise out_valid on the next cycle (latency: 1 cycle from last byte to out_valid).
REQ-017 In HOLD, out_word and out_valid SHALL stay stable until an output transfer.
REQ-018 In HOLD, in_ready SHALL equal out_ready (combinational).
REQ-019 Output transfer without input transfer SHALL return to FILL with byte_cnt 0.
REQ-020 Simultaneous output and input transfer in HOLD SHALL place the new byte in the first lane, set byte_cnt to 1 and return to FILL; no bubble, no byte loss.
REQ-021 in_valid with in_ready low SHALL not alter any state; the source must hold the byte.
REQ-022 Lanes not yet written in the current word SHALL read 0 in out_word.
REQ-023 clr SHALL, next cycle, clear byte_cnt, out_word and out_valid and enter FILL; clr overrides any transfer in the same cycle.
REQ-024 out_word SHALL not change while byte_cnt advances unless a lane is written.

Reset
REQ-025 reset SHALL take priority over clr and all transfers.
REQ-026 After reset: state FILL, byte_cnt 0, out_word 32'h0000_0000, out_valid 0, in_ready 1.
REQ-027 Reset asserted mid-word or in HOLD SHALL discard all held data with no output transfer.

Structure
REQ-028 Shared package SHALL hold the state encoding (FILL=1'b0, HOLD=1'b1), BYTES_PER_WORD=4 and lane index constants.
REQ-029 One sub-module, byte_lane_dec, SHALL map byte_cnt and MSB_FIRST to a 4-bit one-hot lane write enable.
REQ-030 The packer SHALL contain no multipliers or variable shifts; lane writes use the one-hot enable.

Verification
REQ-031 MSB_FIRST=1, bytes 12,34,56,78 on consecutive cycles, out_ready=1 -> out_valid 1 cycle after byte 78, out_word 32'h12345678.
REQ-032 MSB_FIRST=0, same bytes -> out_word 32'h78563412.
REQ-033 Word AA,BB,CC,DD held with out_ready=0 for 5 cycles -> in_ready 0, out_word stable 32'hAABBCCDD; then out_ready=1 with in_valid byte EE -> next cycle byte_cnt 1, out_word[31:24]=EE, out_valid 0.
REQ-034 Two bytes 11,22 accepted, then clr with in_valid byte 33 -> byte_cnt 0, out_word 0; next four bytes 01,02,03,04 -> 32'h01020304.
REQ-035 Word in HOLD, reset asserted together with out_ready=1 -> out_valid 0, byte_cnt 0, no word consumed.
REQ-036 Random in_valid/out_ready over 1000 words, each byte index as value -> scoreboard matches every word; no loss or duplication.

Source files
------------

// File: rtl/byte_packer_pkg.sv
// Shared definitions for the byte packer: state encoding, word geometry and lane indices.
package byte_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_BITS      = 8;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    // byte_cnt value at which the incoming byte completes a word
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/byte_packer_lane_dec.sv
// Maps the current byte count to a one-hot lane write enable, honouring byte order.
module byte_lane_dec
    import byte_packer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [1:0] byte_cnt,
    output logic [3:0] lane_en
);

    logic [1:0] lane;

    always_comb begin
        lane    = MSB_FIRST ? (LANE3 - byte_cnt) : byte_cnt;
        lane_en = 4'b0000;
        case (lane)
            LANE0:   lane_en = 4'b0001;
            LANE1:   lane_en = 4'b0010;
            LANE2:   lane_en = 4'b0100;
            LANE3:   lane_en = 4'b1000;
            default: lane_en = 4'b0000;
        endcase
    end

endmodule

// File: rtl/byte_packer.sv
// Packs a byte stream into 32-bit words; a full word is held until the consumer takes it.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_word,
    input  logic        out_ready,
    output logic [1:0]  byte_cnt
);

    // Handshake: a transfer happens on a cycle where valid && ready are both high;
    // a source seeing valid without ready must hold its data unchanged.

    state_t      state, state_next;
    logic [1:0]  cnt_next;
    logic [31:0] word_next;
    logic [31:0] base_word;
    logic [31:0] written_word;
    logic [3:0]  lane_en;
    logic        in_fire;
    logic        out_fire;

    byte_lane_dec #(
        .MSB_FIRST(MSB_FIRST)
    ) u_lane_dec (
        .byte_cnt(byte_cnt),
        .lane_en (lane_en)
    );

    always_comb begin
        in_ready  = (state == FILL) ? 1'b1 : out_ready;
        out_valid = (state == HOLD);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;

        // A byte arriving in HOLD starts a fresh word, so unwritten lanes read zero
        base_word    = (state == HOLD) ? 32'h0000_0000 : out_word;
        written_word = base_word;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (lane_en[i]) begin
                written_word[i*LANE_BITS +: LANE_BITS] = in_byte;
            end
        end

        state_next = state;
        cnt_next   = byte_cnt;
        word_next  = out_word;

        if (clr) begin
            state_next = FILL;
            cnt_next   = 2'd0;
            word_next  = 32'h0000_0000;
        end else begin
            case (state)
                FILL: begin
                    if (in_fire) begin
                        word_next = written_word;
                        if (byte_cnt == LAST_BYTE) begin
                            state_next = HOLD;
                            cnt_next   = 2'd0;
                        end else begin
                            cnt_next = byte_cnt + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        state_next = FILL;
                        if (in_fire) begin
                            word_next = written_word;
                            cnt_next  = 2'd1;
                        end else begin
                            word_next = 32'h0000_0000;
                            cnt_next  = 2'd0;
                        end
                    end
                end
                default: begin
                    state_next = FILL;
                    cnt_next   = 2'd0;
                    word_next  = 32'h0000_0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FILL;
            byte_cnt <= 2'd0;
            out_word <= 32'h0000_0000;
        end else begin
            state    <= state_next;
            byte_cnt <= cnt_next;
            out_word <= word_next;
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
// Bench for byte_packer: directed vector table on both byte orders, then a randomized stream.
module tb_byte_packer;

    logic        clk;
    logic        reset;
    logic        clr;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        out_ready;

    logic        in_ready_m, out_valid_m, in_ready_l, out_valid_l;
    logic [31:0] out_word_m, out_word_l;
    logic [1:0]  byte_cnt_m, byte_cnt_l;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_l_q[$];

    typedef struct {
        logic        valid;
        logic [7:0]  b;
        logic        ordy;
        logic        clr;
        logic        rst;
        logic        exp_ir;
        logic        exp_ov;
        logic [1:0]  exp_cnt;
        logic [31:0] exp_wm;
        logic [31:0] exp_wl;
    } vec_t;

    vec_t vecs[$];

    byte_packer #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready_m), .out_valid(out_valid_m), .out_word(out_word_m),
        .out_ready(out_ready), .byte_cnt(byte_cnt_m)
    );

    byte_packer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready_l), .out_valid(out_valid_l), .out_word(out_word_l),
        .out_ready(out_ready), .byte_cnt(byte_cnt_l)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] b, input logic ordy, input logic c,
                       input logic r, input logic ir, input logic ov, input logic [1:0] cnt,
                       input logic [31:0] wm, input logic [31:0] wl);
        vec_t t;
        t.valid = v; t.b = b; t.ordy = ordy; t.clr = c; t.rst = r;
        t.exp_ir = ir; t.exp_ov = ov; t.exp_cnt = cnt; t.exp_wm = wm; t.exp_wl = wl;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [7:0] b, input logic ordy,
                         input logic c, input logic r);
        in_valid  = v;
        in_byte   = b;
        out_ready = ordy;
        clr       = c;
        reset     = r;
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].b, vecs[i].ordy, vecs[i].clr, vecs[i].rst);
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready_m), 32'(vecs[i].exp_ir));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid_m), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d_byte_cnt", i), 32'(byte_cnt_m), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_word_msb", i), out_word_m, vecs[i].exp_wm);
            check($sformatf("vec%0d_word_lsb", i), out_word_l, vecs[i].exp_wl);
            check($sformatf("vec%0d_lsb_cnt", i), 32'(byte_cnt_l), 32'(vecs[i].exp_cnt));
        end
    endtask

    // Reference model: every 4 accepted bytes form one word; a word is held from the
    // cycle after its 4th byte until the consumer takes it.
    task automatic run_random(input int words);
        int         accepted = 0;
        int         taken    = 0;
        int         cycles   = 0;
        logic [7:0] pend[$];
        logic       held, exp_ir;
        while (taken < words && cycles < 60000) begin
            @(negedge clk);
            drive($urandom_range(0, 3) != 0, accepted[7:0], $urandom_range(0, 3) != 0, 1'b0, 1'b0);
            #1;
            held   = (accepted / 4) > taken;
            exp_ir = !held || out_ready;
            check("rnd_in_ready", 32'(in_ready_m), 32'(exp_ir));
            check("rnd_out_valid", 32'(out_valid_m), 32'(held));
            check("rnd_lsb_out_valid", 32'(out_valid_l), 32'(held));
            check("rnd_byte_cnt", 32'(byte_cnt_m), 32'(accepted % 4));
            if (held && out_ready) begin
                check("rnd_word_msb", out_word_m, exp_q.pop_front());
                check("rnd_word_lsb", out_word_l, exp_l_q.pop_front());
                taken++;
            end
            if (in_valid && exp_ir) begin
                pend.push_back(in_byte);
                accepted++;
                if (pend.size() == 4) begin
                    exp_q.push_back({pend[0], pend[1], pend[2], pend[3]});
                    exp_l_q.push_back({pend[3], pend[2], pend[1], pend[0]});
                    pend.delete();
                end
            end
            cycles++;
        end
        check("rnd_words_done", 32'(taken), 32'(words));
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);

        //   v  byte   ordy clr rst | ir ov cnt  word_msb       word_lsb
        add(0, 8'h00, 1, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000);
        add(1, 8'h12, 1, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000);
        add(1, 8'h34, 1, 0, 0, 1, 0, 1, 32'h1200_0000, 32'h0000_0012);
        add(1, 8'h56, 1, 0, 0, 1, 0, 2, 32'h1234_0000, 32'h0000_3412);
        add(1, 8'h78, 1, 0, 0, 1, 0, 3, 32'h1234_5600, 32'h0056_3412);
        add(0, 8'h00, 1, 0, 0, 1, 1, 0, 32'h1234_5678, 32'h7856_3412);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000);
        add(1, 8'hAA, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000);
        add(1, 8'hBB, 0, 0, 0, 1, 0, 1, 32'hAA00_0000, 32'h0000_00AA);
        add(1, 8'hCC, 0, 0, 0, 1, 0, 2, 32'hAABB_0000, 32'h0000_BBAA);
        add(1, 8'hDD, 0, 0, 0, 1, 0, 3, 32'hAABB_CC00, 32'h00CC_BBAA);
        for (int k = 0; k < 5; k++)
            add(1, 8'hEE, 0, 0, 0, 0, 1, 0, 32'hAABB_CCDD, 32'hDDCC_BBAA);
        add(1, 8'hEE, 1, 0, 0, 1, 1, 0, 32'hAABB_CCDD, 32'hDDCC_BBAA);
        add(0, 8'h00, 0, 1, 0, 1, 0, 1, 32'hEE00_0000, 32'h0000_00EE);
        add(1, 8'h11, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000);
        add(1, 8'h22, 0, 0, 0, 1, 0, 1, 32'h1100_0000, 32'h0000_0011);
        add(1, 8'h33, 0, 1, 0, 1, 0, 2, 32'h1122_0000, 32'h0000_2211);
        add(1, 8'h01, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000);
        add(1, 8'h02, 0, 0, 0, 1, 0, 1, 32'h0100_0000, 32'h0000_0001);
        add(1, 8'h03, 0, 0, 0, 1, 0, 2, 32'h0102_0000, 32'h0000_0201);
        add(1, 8'h04, 0, 0, 0, 1, 0, 3, 32'h0102_0300, 32'h0003_0201);
        add(0, 8'h00, 0, 0, 0, 0, 1, 0, 32'h0102_0304, 32'h0403_0201);
        add(0, 8'h00, 1, 0, 1, 1, 1, 0, 32'h0102_0304, 32'h0403_0201);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000);
        add(1, 8'h55, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000);
        add(0, 8'h00, 0, 0, 1, 1, 0, 1, 32'h5500_0000, 32'h0000_0055);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000);
        add(1, 8'hA1, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000);
        add(1, 8'hA2, 0, 0, 0, 1, 0, 1, 32'hA100_0000, 32'h0000_00A1);
        add(1, 8'hA3, 0, 0, 0, 1, 0, 2, 32'hA1A2_0000, 32'h0000_A2A1);
        add(1, 8'hA4, 0, 0, 0, 1, 0, 3, 32'hA1A2_A300, 32'h00A3_A2A1);
        add(1, 8'hB0, 1, 1, 0, 1, 1, 0, 32'hA1A2_A3A4, 32'hA4A3_A2A1);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 32'h0000_0000);

        run_table();

        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        run_random(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
